bf16_accumulator: RTL and testbench
===================================

// Module: bf16_accumulator
// PURPOSE
//  Streaming bf16 accumulator, directly downstream of float_multiplier_bf16.
//  Consumes one bf16 product per accepted beat and keeps a running bf16 sum.
//  Emits the sum on a valid/ready output when a beat tagged in_last is accepted.
//  Together with the multiplier this forms the dot-product datapath.
// PARAMETERS
//  MAX_LEN  256  maximum beats per vector; beat MAX_LEN forces termination
//  CNT_W    $clog2(MAX_LEN+1)  width of out_count (derived, not overridden)
// PORTS
//  clock         in   1      single clock; all state updates on posedge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      product beat valid
//  in_ready      out  1      accumulator can accept a beat
//  in_data       in   16     bf16 product (from float_multiplier_bf16 y)
//  in_last       in   1      final beat of the current vector
//  out_valid     out  1      sum available
//  out_ready     in   1      consumer accepts sum
//  out_data      out  16     bf16 sum
//  out_count     out  CNT_W  number of beats summed
//  out_truncated out  1      vector ended by MAX_LEN, not by in_last
// BEHAVIOUR
//  Reset: state=ACCUM, acc=16'h0000, count=0, out_valid=0, out_data=0,
//   out_count=0, out_truncated=0, in_ready=1. Reset wins over every other event,
//   including mid-vector and while out_valid=1; the partial sum is discarded.
//  FSM, 2 states:
//   ACCUM: in_ready=1, out_valid=0. On in_valid&in_ready: acc<=acc+in_data,
//    count<=count+1. If in_last, or count==MAX_LEN-1: out_data<=acc+in_data,
//    out_count<=count+1, out_truncated<=~in_last, acc<=0, count<=0 -> DONE.
//   DONE: in_ready=0, out_valid=1; out_data, out_count and out_truncated stay
//    stable until handshake. On out_ready -> ACCUM (in_ready=1 on the next
//    cycle; no same-cycle input acceptance).
//  Latency: out_valid rises the cycle after the last beat is accepted.
//   Throughput: 1 beat/cycle inside a vector; 1 bubble cycle per vector minimum.
//  A one-beat vector (in_last on the first beat) yields out_data=in_data+0.
//  Addition (float_adder_bf16, combinational): IEEE-style bf16 with 1 sign,
//   8 exponent, 7 mantissa bits, bias 127. Round to nearest, ties to even, using
//   guard, round and sticky bits.
//   - Subnormal inputs are flushed to a signed zero. A subnormal result is
//     flushed to +0.
//   - Exact cancellation and +0 + -0 give +0 (16'h0000). -0 + -0 gives 16'h8000.
//   - Overflow after rounding gives signed inf (7f80/ff80).
//   - Any NaN operand, or +inf + -inf, gives canonical qNaN 16'h7fc0.
//   - inf + finite gives that inf. A NaN/inf in acc is sticky for the vector.
//  in_data and in_last are ignored when in_valid=0. in_valid may drop without
//   penalty; the sum is held across idle cycles.
// STRUCTURE
//  float_pkg (shared with the multipliers): BF16_EXP_W=8, BF16_MAN_W=7,
//   BF16_BIAS=127, BF16_QNAN=16'h7fc0, BF16_PINF=16'h7f80, BF16_NINF=16'hff80,
//   and the accumulator state enum {ACCUM, DONE}.
//  Sub-module: float_adder_bf16(a, b, y), purely combinational. It does alignment,
//   add/sub, normalisation via a leading-zero count, rounding, and the special
//   cases. It is reused later by the bf16 adder tree.
//  Top level holds the FSM, acc/count registers and output registers only.
// TESTING
//  1) Beats 3f80, 4000, 4040(last) with out_ready=1 -> out_data=40c0,
//     out_count=3, out_truncated=0, out_valid exactly one cycle after beat 3.
//  2) Beats 3f80, bf80(last) -> out_data=0000. Beats 8000, 8000(last) -> 8000.
//  3) Rounding: 4380, 3f80(last) (256+1) -> 4380 (tie to even). 4380, 4000,
//     3f80(last) -> 4382 (256+2+1=259 ties up to 260).
//  4) Specials: 7f80, ff80(last) -> 7fc0. 7f80, 3f80(last) -> 7f80.
//     7f7f, 7f7f(last) -> 7f80. 0001, 0000(last) -> 0000.
//  5) Backpressure: after last, hold out_ready=0 for 3 cycles -> out_valid=1,
//     in_ready=0, out_data stable; inputs presented meanwhile are not summed.
//     Then out_ready=1 -> next vector starts from acc=0.
//  6) MAX_LEN=4, 5 beats of 3f80 without last -> first result 4080, count=4,
//     truncated=1. Then 3f80(last) -> 3f80, count=1. Reset asserted mid-vector
//     -> all outputs at reset values next cycle; the following vector is correct.

Source files
------------

// File: rtl/bf16_accumulator_pkg.sv
// Shared bf16 constants, accumulator state type and a leading-zero counter
// for the normalisation step of the bf16 adder.
package bf16_accumulator_pkg;

  localparam int unsigned BF16_W     = 16;
  localparam int unsigned BF16_EXP_W = 8;
  localparam int unsigned BF16_MAN_W = 7;
  localparam int unsigned BF16_BIAS  = 127;

  localparam logic [BF16_W-1:0] BF16_QNAN  = 16'h7fc0;
  localparam logic [BF16_W-1:0] BF16_PINF  = 16'h7f80;
  localparam logic [BF16_W-1:0] BF16_NINF  = 16'hff80;
  localparam logic [BF16_W-1:0] BF16_NZERO = 16'h8000;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_e;

  // Leading zeros of an 11-bit value; 11 when the value is zero.
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/bf16_accumulator_adder.sv
// Combinational bf16 adder: align, add/sub, normalise, round-to-nearest-even,
// with subnormal flushing and IEEE-style special-value handling.
module float_adder_bf16
  import bf16_accumulator_pkg::*;
(
  input  logic [BF16_W-1:0] a_i,
  input  logic [BF16_W-1:0] b_i,
  output logic [BF16_W-1:0] y_o
);

  localparam int unsigned MW = BF16_MAN_W;
  localparam int unsigned EW = BF16_EXP_W;
  // hidden bit + mantissa + guard/round/sticky
  localparam int unsigned XW = MW + 4;
  localparam logic signed [9:0] E_INF = 10'(2 * BF16_BIAS + 1);

  logic [EW-1:0]     ea, eb, e_big, e_sml, d;
  logic [MW-1:0]     ma, mb, frac;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              swap, s_big, sub, st, rnd, c_r;
  logic [MW:0]       m_big, m_sml;
  logic [XW-1:0]     al, sh, nrm;
  logic [XW:0]       sum;
  logic [3:0]        lz;
  logic signed [9:0] e_n;

  always_comb begin
    ea     = a_i[MW +: EW];
    eb     = b_i[MW +: EW];
    ma     = a_i[MW-1:0];
    mb     = b_i[MW-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);

    swap   = b_i[BF16_W-2:0] > a_i[BF16_W-2:0];
    e_big  = swap ? eb : ea;
    e_sml  = swap ? ea : eb;
    m_big  = {1'b1, swap ? mb : ma};
    m_sml  = {1'b1, swap ? ma : mb};
    s_big  = swap ? b_i[BF16_W-1] : a_i[BF16_W-1];
    sub    = a_i[BF16_W-1] ^ b_i[BF16_W-1];
    d      = e_big - e_sml;

    // Align the smaller operand, folding every shifted-out bit into sticky.
    al = {m_sml, 3'b000};
    if (d >= EW'(XW)) begin
      st = 1'b1;
      sh = XW'(1);
    end else begin
      st    = |(al & ~({XW{1'b1}} << d));
      sh    = al >> d;
      sh[0] = sh[0] | st;
    end

    sum = sub ? ({1'b0, m_big, 3'b000} - {1'b0, sh})
              : ({1'b0, m_big, 3'b000} + {1'b0, sh});
    lz  = lzc11(sum[XW-1:0]);

    if (sum[XW]) begin
      nrm = {sum[XW:2], sum[1] | sum[0]};
      e_n = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      nrm = sum[XW-1:0] << lz;
      e_n = $signed({2'b00, e_big}) - $signed({6'd0, lz});
    end

    rnd        = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    {c_r, frac} = {1'b0, nrm[XW-2:3]} + (MW + 1)'(rnd);
    if (c_r) e_n = e_n + 10'sd1;

    y_o = {s_big, e_n[EW-1:0], frac};
    if (e_n >= E_INF) y_o = s_big ? BF16_NINF : BF16_PINF;
    if (!nrm[XW-1] || e_n <= 10'sd0) y_o = '0;

    // Zero operands (including flushed subnormals), then infinities, then NaNs.
    if (a_zero && b_zero) y_o = {a_i[BF16_W-1] & b_i[BF16_W-1], (BF16_W - 1)'(0)};
    else if (a_zero)      y_o = b_i;
    else if (b_zero)      y_o = a_i;
    if (a_inf || b_inf)   y_o = a_inf ? a_i : b_i;
    if ((a_inf && b_inf && sub) || a_nan || b_nan) y_o = BF16_QNAN;
  end

endmodule

// File: rtl/bf16_accumulator.sv
// Streaming bf16 accumulator: sums product beats until in_last or MAX_LEN beats,
// then presents the sum, beat count and truncation flag on a valid/ready port.
module bf16_accumulator
  import bf16_accumulator_pkg::*;
#(
  parameter  int unsigned MAX_LEN = 256,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [BF16_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BF16_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  out_count_o,
  output logic              out_truncated_o
);

  acc_state_e        state_q;
  logic [BF16_W-1:0] acc_q, addend, sum_d, out_data_q;
  logic [CNT_W-1:0]  count_q, out_count_q;
  logic              in_ready_q, out_valid_q, out_truncated_q, end_beat;

  // An empty sum acts as -0, the exact additive identity, so -0 beats stay -0.
  assign addend   = (count_q == '0) ? BF16_NZERO : acc_q;
  assign end_beat = in_last_i || (count_q == CNT_W'(MAX_LEN - 1));

  float_adder_bf16 u_add (
    .a_i (addend),
    .b_i (in_data_i),
    .y_o (sum_d)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q         <= ACCUM;
      acc_q           <= '0;
      count_q         <= '0;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_count_q     <= '0;
      out_truncated_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid_i && in_ready_q) begin
            if (end_beat) begin
              out_data_q      <= sum_d;
              out_count_q     <= count_q + CNT_W'(1);
              out_truncated_q <= ~in_last_i;
              acc_q           <= '0;
              count_q         <= '0;
              in_ready_q      <= 1'b0;
              out_valid_q     <= 1'b1;
              state_q         <= DONE;
            end else begin
              acc_q   <= sum_d;
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign out_count_o     = out_count_q;
  assign out_truncated_o = out_truncated_q;

endmodule

// File: tb/tb_bf16_accumulator.sv
// Scoreboard bench for bf16_accumulator: real-arithmetic reference model,
// directed vectors with fixed expectations, then randomized traffic.
module tb_bf16_accumulator;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = 16'h0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_truncated;

  always #5 clk = ~clk;

  bf16_accumulator #(.MAX_LEN(MAX_LEN)) dut (
    .clock_i         (clk),
    .reset_i         (reset),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .in_last_i       (in_last),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_data_o      (out_data),
    .out_count_o     (out_count),
    .out_truncated_o (out_truncated)
  );

  typedef struct {
    logic [15:0] data;
    int          cnt;
    bit          trunc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        dir_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 2;
  logic [15:0] m_acc = 16'h8000;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact sum in double precision, then one rounding to 8 significant bits.
  function automatic real to_real(input logic [15:0] a);
    if (a[14:0] == 15'd0) return 0.0;
    return $bitstoreal({a[15], 11'(a[14:7]) + 11'd896, a[6:0], 45'd0});
  endfunction

  function automatic logic [15:0] from_real(input real s);
    logic [63:0] bits;
    logic [52:0] mant;
    logic [8:0]  q;
    int          e, be;
    bit          up;
    bits = $realtobits(s);
    e    = int'(bits[62:52]) - 1023;
    mant = {1'b1, bits[51:0]};
    q    = {1'b0, mant[52:45]};
    up   = mant[44] && ((mant[43:0] != 44'd0) || mant[45]);
    q    = q + 9'(up);
    if (q[8]) begin
      q = q >> 1;
      e++;
    end
    be = e + 127;
    if (be >= 255) return bits[63] ? 16'hff80 : 16'h7f80;
    if (be <= 0) return 16'h0000;
    return {bits[63], be[7:0], q[6:0]};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b;
    real         s;
    a = a_in;
    b = b_in;
    if ((a[14:7] == 8'hff && a[6:0] != 0) || (b[14:7] == 8'hff && b[6:0] != 0)) return 16'h7fc0;
    if (a[14:0] == 15'h7f80 && b[14:0] == 15'h7f80) return (a[15] != b[15]) ? 16'h7fc0 : a;
    if (a[14:0] == 15'h7f80) return a;
    if (b[14:0] == 15'h7f80) return b;
    if (a[14:7] == 8'h00) a = {a[15], 15'd0};
    if (b[14:7] == 8'h00) b = {b[15], 15'd0};
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return {a[15] & b[15], 15'd0};
    s = to_real(a) + to_real(b);
    if (s == 0.0) return 16'h0000;
    return from_real(s);
  endfunction

  function automatic logic [15:0] rand_bf16();
    int unsigned r;
    r = $urandom_range(0, 31);
    case (r)
      0: return 16'h8000;
      1: return 16'h0000;
      2: return 16'h7f80;
      3: return 16'hff80;
      4: return 16'h7fc0;
      5: return 16'h0003;
      6: return 16'h7f7f;
      7: return 16'hff7f;
      default: return {1'($urandom), 8'($urandom_range(118, 136)), 7'($urandom)};
    endcase
  endfunction

  // Consumer side: random, always-ready or stalled.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares every accepted sum and checks that stalled outputs hold.
  logic             stall_v = 1'b0;
  logic [15:0]      stall_d;
  logic [CNT_W-1:0] stall_c;
  logic             stall_t;
  exp_t             mon_e;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, stall_d);
          chk("hold_count", out_count, stall_c);
          chk("hold_trunc", out_truncated, stall_t);
        end
        stall_v = 1'b0;
        if (out_valid) begin
          chk("busy_in_ready", in_ready, 0);
          if (out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_output: got %h with nothing expected", out_data);
            end else begin
              checks--;
              mon_e = exp_q.pop_front();
              chk("sum", out_data, mon_e.data);
              chk("count", out_count, mon_e.cnt);
              chk("truncated", out_truncated, mon_e.trunc);
            end
          end else begin
            stall_v = 1'b1;
            stall_d = out_data;
            stall_c = out_count;
            stall_t = out_truncated;
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic l);
    int   t;
    bit   ok, rdy;
    exp_t e;
    t  = 0;
    ok = 0;
    while (!ok) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      rdy      = in_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1;
      else begin
        t++;
        if (t > 100) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: beat %h never accepted", d);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    m_acc = ref_add(m_acc, d);
    m_cnt++;
    if (l || m_cnt == int'(MAX_LEN)) begin
      if (dir_q.size() != 0) e = dir_q.pop_front();
      else e = '{m_acc, m_cnt, !l};
      exp_q.push_back(e);
      chk("latency_out_valid", out_valid, 1);
      chk("latency_in_ready", in_ready, 0);
      m_acc = 16'h8000;
      m_cnt = 0;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset(input int cycles);
    int saved;
    saved    = rdy_mode;
    rdy_mode = 2;
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_trunc", out_truncated, 0);
    reset = 1'b0;
    exp_q.delete();
    m_acc    = 16'h8000;
    m_cnt    = 0;
    rdy_mode = saved;
  endtask

  initial begin
    do_reset(2);
    rdy_mode = 1;

    dir_q.push_back('{16'h40c0, 3, 1'b0});
    send_beat(16'h3f80, 1'b0); send_beat(16'h4000, 1'b0); send_beat(16'h4040, 1'b1);
    dir_q.push_back('{16'h0000, 2, 1'b0});
    send_beat(16'h3f80, 1'b0); send_beat(16'hbf80, 1'b1);
    dir_q.push_back('{16'h8000, 2, 1'b0});
    send_beat(16'h8000, 1'b0); send_beat(16'h8000, 1'b1);
    dir_q.push_back('{16'h4380, 2, 1'b0});
    send_beat(16'h4380, 1'b0); send_beat(16'h3f80, 1'b1);
    dir_q.push_back('{16'h4382, 3, 1'b0});
    send_beat(16'h4380, 1'b0); send_beat(16'h4000, 1'b0); send_beat(16'h3f80, 1'b1);
    dir_q.push_back('{16'h7fc0, 2, 1'b0});
    send_beat(16'h7f80, 1'b0); send_beat(16'hff80, 1'b1);
    dir_q.push_back('{16'h7f80, 2, 1'b0});
    send_beat(16'h7f80, 1'b0); send_beat(16'h3f80, 1'b1);
    dir_q.push_back('{16'h7f80, 2, 1'b0});
    send_beat(16'h7f7f, 1'b0); send_beat(16'h7f7f, 1'b1);
    dir_q.push_back('{16'h0000, 2, 1'b0});
    send_beat(16'h0001, 1'b0); send_beat(16'h0000, 1'b1);
    drain();

    // Backpressure: stalled result must hold while offered beats are ignored.
    rdy_mode = 2;
    dir_q.push_back('{16'h4040, 2, 1'b0});
    send_beat(16'h3f80, 1'b0); send_beat(16'h4000, 1'b1);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h3f80;
      in_last  = 1'b0;
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_data", out_data, 16'h4040);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    dir_q.push_back('{16'h3f80, 1, 1'b0});
    send_beat(16'h3f80, 1'b1);

    // MAX_LEN truncation, then a one-beat vector.
    dir_q.push_back('{16'h4080, 4, 1'b1});
    repeat (4) send_beat(16'h3f80, 1'b0);
    dir_q.push_back('{16'h3f80, 1, 1'b0});
    send_beat(16'h3f80, 1'b1);
    drain();

    // Reset mid-vector and while a result is pending.
    send_beat(16'h3f80, 1'b0); send_beat(16'h4000, 1'b0);
    do_reset(1);
    dir_q.push_back('{16'h4040, 1, 1'b0});
    send_beat(16'h4040, 1'b1);
    drain();
    rdy_mode = 2;
    send_beat(16'h3f80, 1'b1);
    do_reset(1);
    rdy_mode = 1;
    dir_q.push_back('{16'h4000, 2, 1'b0});
    send_beat(16'h3f80, 1'b0); send_beat(16'h3f80, 1'b1);
    drain();

    rdy_mode = 0;
    for (int v = 0; v < 60; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send_beat(rand_bf16(), 1'(k == len - 1));
      end
    end
    rdy_mode = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
